// File: rtl/luks_sensor_emu.sv
// SPI responder emulating the ambient-light sensor: serves one zero-padded,
// MSB-first light sample per slave-select, oversampling SS/SCLK on clk.
module luks_sensor_emu #(
   parameter int LEAD_ZEROS  = 3,
   parameter int DATA_W      = 8,
   parameter int TRAIL_ZEROS = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_i,
   input  logic              sample_load_i,
   input  logic              ss,
   input  logic              sclk,
   output logic              miso,
   output logic              miso_oe,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              frame_abort_o
);

   localparam int FRAME_LEN = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic                   ss_hist;
   logic                   sclk_hist;
   logic [SYNC_STAGES:0]   warm;
   logic                   armed;
   logic [DATA_W-1:0]      shadow;
   logic [FRAME_LEN-1:0]   shift_reg;
   logic [FRAME_LEN-1:0]   framed;
   logic [CNT_W-1:0]       cnt;
   logic                   ss_s;
   logic                   sclk_s;
   logic                   ss_fall;
   logic                   ss_rise;
   logic                   sclk_fall;
   logic                   last_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         ss_hist   <= 1'b1;
         sclk_hist <= 1'b0;
         warm      <= '0;
         armed     <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         ss_hist   <= ss_sync[SYNC_STAGES-1];
         sclk_hist <= sclk_sync[SYNC_STAGES-1];
         warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
         // A frame already selected at reset release must not start: only arm
         // once real (post-reset) SS data has been seen high.
         armed     <= armed | (warm[SYNC_STAGES] & ss_sync[SYNC_STAGES-1]);
      end
   end

   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ss_fall   = armed & ss_hist & ~ss_s;
   assign ss_rise   = ~ss_hist & ss_s;
   assign sclk_fall = sclk_hist & ~sclk_s;
   assign last_bit  = (cnt == CNT_W'(FRAME_LEN - 1));
   assign framed    = {{(FRAME_LEN-DATA_W){1'b0}}, shadow} << TRAIL_ZEROS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (ss_fall) state_next = SHIFT;
         SHIFT: begin
            if (ss_rise) state_next = IDLE;
            else if (sclk_fall && last_bit) state_next = HOLD;
         end
         HOLD:  if (ss_rise) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow    <= '0;
         shift_reg <= '0;
         cnt       <= '0;
      end else begin
         if (sample_load_i) shadow <= sample_i;
         // Old shadow is framed even if a load lands on the same cycle.
         if (state == IDLE && ss_fall) begin
            shift_reg <= framed;
            cnt       <= '0;
         end else if (state == SHIFT && !ss_rise && sclk_fall) begin
            shift_reg <= shift_reg << 1;
            cnt       <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      miso          = (state == SHIFT) ? shift_reg[FRAME_LEN-1] : 1'b0;
      miso_oe       = (state != IDLE);
      busy_o        = (state != IDLE);
      frame_done_o  = (state == HOLD) && ss_rise;
      frame_abort_o = (state == SHIFT) && ss_rise;
   end

endmodule

// File: tb/tb_luks_sensor_emu.sv
// Self-checking bench for luks_sensor_emu: acts as the SPI master and checks
// captured words against a frame model built from the sensor's frame format.
module tb_luks_sensor_emu;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sample_i;
   logic       sample_load_i;
   logic       ss;
   logic       sclk;
   logic       miso;
   logic       miso_oe;
   logic       busy_o;
   logic       frame_done_o;
   logic       frame_abort_o;

   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   int         abort_cnt = 0;
   logic [7:0] model_shadow = 8'h00;
   logic [7:0] model_frame;

   luks_sensor_emu dut (
      .clk(clk), .rst(rst), .sample_i(sample_i), .sample_load_i(sample_load_i),
      .ss(ss), .sclk(sclk), .miso(miso), .miso_oe(miso_oe), .busy_o(busy_o),
      .frame_done_o(frame_done_o), .frame_abort_o(frame_abort_o)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (frame_done_o)  done_cnt  = done_cnt + 1;
      if (frame_abort_o) abort_cnt = abort_cnt + 1;
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Expected master capture: 3 zeros, sample MSB-first, 5 zeros, then zeros.
   function automatic logic [31:0] exp_word(input logic [7:0] v, input int n);
      logic [31:0] w;
      int          idx;
      w = 32'h0;
      for (int i = 0; i < n; i++) begin
         idx = i - 3;
         w = {w[30:0], (idx >= 0 && idx < 8) ? v[7-idx] : 1'b0};
      end
      return w;
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_sample(input logic [7:0] v);
      @(negedge clk);
      sample_i      = v;
      sample_load_i = 1'b1;
      @(negedge clk);
      sample_load_i = 1'b0;
      model_shadow  = v;
   endtask

   task automatic spi_frame(input int ncyc, input int load_at, input logic [7:0] load_val,
                            input bit end_ss, output logic [31:0] word, output int oe_bad);
      word   = 32'h0;
      oe_bad = 0;
      @(negedge clk);
      ss          = 1'b0;
      model_frame = model_shadow;
      wait_clks(HALF);
      for (int i = 0; i < ncyc; i++) begin
         if (miso_oe !== 1'b1) oe_bad++;
         word = {word[30:0], miso};
         sclk = 1'b1;
         wait_clks(HALF);
         sclk = 1'b0;
         if (i == load_at) begin
            load_sample(load_val);
            wait_clks(HALF - 2);
         end else begin
            wait_clks(HALF);
         end
      end
      if (end_ss) begin
         ss = 1'b1;
         wait_clks(HALF);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; ss = 1'b1; sclk = 1'b0; sample_i = 8'h00; sample_load_i = 1'b0;
      wait_clks(3);
      n_cmp++;
      if ({miso, miso_oe, busy_o, frame_done_o, frame_abort_o} !== 5'b0) begin
         n_err++;
         $display("[TB] FAIL reset_outputs: got %b want 00000",
                  {miso, miso_oe, busy_o, frame_done_o, frame_abort_o});
      end
      rst = 1'b0;
      wait_clks(10);
      n_cmp++;
      if ({miso_oe, busy_o} !== 2'b00) begin
         n_err++;
         $display("[TB] FAIL idle_after_reset: got %b want 00", {miso_oe, busy_o});
      end
   endtask

   task automatic test_full_frame;
      logic [31:0] w;
      int          oe_bad, d0, a0;
      load_sample(8'hA5);
      d0 = done_cnt; a0 = abort_cnt;
      spi_frame(16, -1, 8'h00, 1'b1, w, oe_bad);
      n_cmp++;
      if (w !== 32'h14A0) begin
         n_err++;
         $display("[TB] FAIL full_frame_word: got %h want 000014a0", w);
      end
      n_cmp++;
      if (done_cnt - d0 != 1 || abort_cnt != a0 || oe_bad != 0) begin
         n_err++;
         $display("[TB] FAIL full_frame_pulses: done %0d abort %0d oe_bad %0d want 1 0 0",
                  done_cnt - d0, abort_cnt - a0, oe_bad);
      end
   endtask

   task automatic test_extremes;
      logic [31:0] w;
      int          oe_bad;
      logic [7:0]  vals [2] = '{8'h00, 8'hFF};
      for (int k = 0; k < 2; k++) begin
         load_sample(vals[k]);
         n_cmp++;
         if (miso_oe !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL oe_between_frames: got %b want 0", miso_oe);
         end
         spi_frame(16, -1, 8'h00, 1'b1, w, oe_bad);
         n_cmp++;
         if (w !== exp_word(vals[k], 16) || oe_bad != 0) begin
            n_err++;
            $display("[TB] FAIL extreme_word: got %h want %h (oe_bad %0d)",
                     w, exp_word(vals[k], 16), oe_bad);
         end
      end
   endtask

   task automatic test_mid_frame_load;
      logic [31:0] w;
      int          oe_bad;
      load_sample(8'h3C);
      spi_frame(16, 6, 8'hC3, 1'b1, w, oe_bad);
      n_cmp++;
      if (w !== exp_word(8'h3C, 16)) begin
         n_err++;
         $display("[TB] FAIL mid_load_frame1: got %h want %h", w, exp_word(8'h3C, 16));
      end
      spi_frame(16, -1, 8'h00, 1'b1, w, oe_bad);
      n_cmp++;
      if (w !== exp_word(8'hC3, 16)) begin
         n_err++;
         $display("[TB] FAIL mid_load_frame2: got %h want %h", w, exp_word(8'hC3, 16));
      end
   endtask

   task automatic test_abort;
      logic [31:0] w;
      int          oe_bad, d0, a0;
      load_sample(8'h5A);
      d0 = done_cnt; a0 = abort_cnt;
      spi_frame(7, -1, 8'h00, 1'b1, w, oe_bad);
      n_cmp++;
      if (done_cnt != d0 || abort_cnt - a0 != 1) begin
         n_err++;
         $display("[TB] FAIL abort_pulses: done %0d abort %0d want 0 1", done_cnt - d0, abort_cnt - a0);
      end
      n_cmp++;
      if (w !== exp_word(8'h5A, 7) || miso_oe !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL abort_partial: got %h oe %b want %h oe 0", w, miso_oe, exp_word(8'h5A, 7));
      end
      spi_frame(16, -1, 8'h00, 1'b1, w, oe_bad);
      n_cmp++;
      if (w !== exp_word(8'h5A, 16)) begin
         n_err++;
         $display("[TB] FAIL after_abort_word: got %h want %h", w, exp_word(8'h5A, 16));
      end
   endtask

   task automatic test_overclock;
      logic [31:0] w;
      int          oe_bad, d0;
      load_sample(8'h96);
      d0 = done_cnt;
      spi_frame(20, -1, 8'h00, 1'b1, w, oe_bad);
      n_cmp++;
      if (w !== exp_word(8'h96, 20) || done_cnt - d0 != 1) begin
         n_err++;
         $display("[TB] FAIL overclock: got %h done %0d want %h done 1", w, done_cnt - d0, exp_word(8'h96, 20));
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] w;
      int          oe_bad, d0, a0, bad;
      load_sample(8'h77);
      d0 = done_cnt; a0 = abort_cnt;
      spi_frame(9, -1, 8'h00, 1'b0, w, oe_bad);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({miso, miso_oe, busy_o, frame_done_o, frame_abort_o} !== 5'b0) begin
         n_err++;
         $display("[TB] FAIL reset_mid_outputs: got %b want 00000",
                  {miso, miso_oe, busy_o, frame_done_o, frame_abort_o});
      end
      wait_clks(2);
      rst = 1'b0;
      model_shadow = 8'h00;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         sclk = 1'b1;
         wait_clks(HALF);
         if (busy_o !== 1'b0 || miso_oe !== 1'b0) bad++;
         sclk = 1'b0;
         wait_clks(HALF);
         if (busy_o !== 1'b0 || miso_oe !== 1'b0) bad++;
      end
      ss = 1'b1;
      wait_clks(HALF);
      n_cmp++;
      if (bad != 0 || done_cnt != d0 || abort_cnt != a0) begin
         n_err++;
         $display("[TB] FAIL reset_mid_quiet: active %0d done %0d abort %0d want 0 0 0",
                  bad, done_cnt - d0, abort_cnt - a0);
      end
      spi_frame(16, -1, 8'h00, 1'b1, w, oe_bad);
      n_cmp++;
      if (w !== exp_word(8'h00, 16)) begin
         n_err++;
         $display("[TB] FAIL reset_cleared_shadow: got %h want %h", w, exp_word(8'h00, 16));
      end
      load_sample(8'hE1);
      spi_frame(16, -1, 8'h00, 1'b1, w, oe_bad);
      n_cmp++;
      if (w !== exp_word(8'hE1, 16)) begin
         n_err++;
         $display("[TB] FAIL after_reset_word: got %h want %h", w, exp_word(8'hE1, 16));
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] w;
      int          oe_bad, d0, ncyc, load_at;
      logic [7:0]  v;
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(1, 0) == 1) load_sample(8'($urandom));
         ncyc    = $urandom_range(18, 16);
         load_at = ($urandom_range(1, 0) == 1) ? $urandom_range(15, 0) : -1;
         v       = 8'($urandom);
         d0      = done_cnt;
         spi_frame(ncyc, load_at, v, 1'b1, w, oe_bad);
         n_cmp++;
         if (w !== exp_word(model_frame, ncyc) || done_cnt - d0 != 1 || oe_bad != 0) begin
            n_err++;
            $display("[TB] FAIL random_frame%0d: got %h done %0d oe_bad %0d want %h done 1 oe_bad 0",
                     k, w, done_cnt - d0, oe_bad, exp_word(model_frame, ncyc));
         end
      end
   endtask

   initial begin
      test_reset;
      test_full_frame;
      test_extremes;
      test_mid_frame_load;
      test_abort;
      test_overclock;
      test_reset_mid_frame;
      test_back_to_back;
      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/luks_sensor_emu.md
Name: luks_sensor_emu

Overview:
- SPI responder (slave) emulating the ambient-light sensor read by the design's sensor SPI master.
- Serves a fixed 16-bit read-only frame on MISO: 3 leading zeros, an 8-bit light sample MSB-first, then 5 trailing zeros.
- Oversamples SS/SCLK in the system clock domain.
- Used on-chip as a loopback/self-test source and in the bench as a synthesizable sensor model.

Parameters:
- LEAD_ZEROS, 3: zero bits sent before the data.
- DATA_W, 8: sample width, sent MSB-first.
- TRAIL_ZEROS, 5: zero bits sent after the data.
- SYNC_STAGES, 2: flop count of the SS/SCLK synchronizers (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- sample_i  input  DATA_W  next light value to serve.
- sample_load_i  input  1  1-cycle strobe; captures sample_i into the shadow register.
- ss  input  1  slave select from master, active low, asynchronous to clk.
- sclk  input  1  SPI clock from master, idle low, asynchronous to clk.
- miso  output  1  serial data to master.
- miso_oe  output  1  high while the frame is selected.
- busy_o  output  1  high in SHIFT or HOLD.
- frame_done_o  output  1  1-cycle pulse on a complete frame.
- frame_abort_o  output  1  1-cycle pulse on SS deassert before a complete frame.

Behaviour:
- Reset values:
  - Outputs: miso=0, miso_oe=0, busy_o=0, frame_done_o=0, frame_abort_o=0.
  - Internal: shadow=0, shift register=0, bit counter=0, state IDLE.
  - Synchronizer flops reset to ss=1, sclk=0.
- FRAME_LEN = LEAD_ZEROS+DATA_W+TRAIL_ZEROS (16 at defaults). Bit counter width is clog2(FRAME_LEN+1).
- Synchronization:
  - SS and SCLK each pass through SYNC_STAGES flops plus one history flop for edge detect.
  - Edge detection is on synchronized values only.
- Timing requirement on the master: SCLK high and low phases each ≥ SYNC_STAGES+2 clk periods. Same minimum for SS-fall-to-first-SCLK-rise.
- Shadow register:
  - sample_load_i writes the shadow in any state.
  - The shadow is copied into the shift register only on the SS falling edge.
  - A load mid-frame affects the next frame only.
  - A load in the same cycle as the SS fall edge: the old shadow value is framed; the new value is kept for the following frame.
- State machine:
  - IDLE:
    - miso=0, miso_oe=0.
    - On sync SS fall: load shift reg = {LEAD zeros, shadow, TRAIL zeros}, counter=0, go to SHIFT.
    - miso_oe=1 and miso = frame bit 0 from the next cycle.
  - SHIFT:
    - On each sync SCLK falling edge: shift left, counter+1, miso = next frame bit. Data changes on the falling edge; the master samples on the rising edge.
    - SCLK rising edges are ignored.
    - When the counter reaches FRAME_LEN (16th falling edge): miso=0, go to HOLD.
  - HOLD:
    - Frame complete; miso stays 0, further SCLK edges are ignored (no wrap-around, no repeat).
    - On sync SS rise: pulse frame_done_o, go to IDLE.
  - Sync SS rise while in SHIFT: pulse frame_abort_o, go to IDLE, miso_oe=0. The partial frame is discarded.
  - SS fall and SCLK fall synchronized in the same cycle: the frame starts; that SCLK edge is not counted.
- Latency: miso_oe high and bit 0 valid SYNC_STAGES+2 clk after the SS fall at the pin. Each bit update follows its SCLK fall by the same latency.
- Reset asserted mid-frame: immediate return to IDLE, miso_oe=0, no done/abort pulse. A frame still in progress when reset releases is ignored until SS returns high and falls again.
- busy_o=1 in SHIFT or HOLD.

Test Plan:
- Full frame: load 0xA5; SS low, 16 SCLK cycles (8 clk half-period) -> master captures 0x00A5<<5 = 0x14A0. frame_done_o pulses once after SS rise.
- Extremes: frames with 0x00 and 0xFF -> captured words 0x0000 and 0x1FE0. miso_oe=0 between frames.
- Mid-frame load: load 0x3C, start frame, load 0xC3 at bit 6 -> frame carries 0x3C; the next frame carries 0xC3.
- Abort: SS rises after 7 SCLK cycles -> frame_abort_o pulses, no frame_done_o. The next full frame returns the correct value.
- Overclock: 20 SCLK cycles in one frame -> bits 16..19 read 0, single frame_done_o.
- Reset mid-frame: assert rst at bit 9 -> all outputs 0 within one clk. After release with SS still low, no activity until a new SS fall.
